load_buffer: RTL and testbench
==============================

Name: load_buffer

Overview:
- Tracks in-flight speculative loads between load issue and reorder-buffer commit.
- Sits beside the reorder buffer:
  - Allocation index (loadbuf_free_entry) is captured by the ROB alongside the load's CDB tag.
  - The ROB returns that index at load commit (loadbuf_commit_entry).
  - The ROB's committed-store port (dmem_we/store_addr) is snooped.
- Raises misload when a committing load was speculatively executed before an older, same-address store committed; the ROB then suppresses the commit and flushes.

Parameters:
IDX_W, 3, entry index width; entries are 1..2^IDX_W-1 (7); index 0 means "no entry"
ADDR_W, 32, data address width
MATCH_LSB, 2, lowest address bit compared (word granularity)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  pipeline kill (ROB mispred or misload); clears all entries next edge
alloc_en  input  1  load issued to memory this cycle; allocate entry free_entry
alloc_addr  input  ADDR_W  effective address of issuing load
free_entry  output  IDX_W  index granted to an allocation this cycle (0 when full)
full  output  1  no free entry; upstream must hold alloc_en low
store_we  input  1  ROB committing a store this cycle
store_addr  input  ADDR_W  committed store address
commit_entry  input  IDX_W  entry of load committing this cycle (0 = none)
misload  output  1  committing load is stale; combinational
occupancy  output  IDX_W  number of valid entries

Behaviour:
- State per entry i (1..7): valid[i], addr[i], hazard[i]. Entry 0 is never allocated and has no storage.
- Reset (reset_n low, async): all valid and hazard bits cleared.
  - Outputs while in reset: free_entry=1, full=0, misload=0, occupancy=0.
- free_entry:
  - Lowest-index i with valid[i]=0, derived from registered state only.
  - 0 and full=1 when all 7 entries are valid.
- Allocation: on a clock edge with alloc_en=1 and full=0: valid[free_entry]<=1, addr<=alloc_addr, hazard<=0.
  - alloc_en with full=1 is ignored; the verification bench flags it as a protocol error.
- Store snoop: on a clock edge with store_we=1, for every valid i with addr[i][ADDR_W-1:MATCH_LSB]==store_addr[ADDR_W-1:MATCH_LSB]: hazard[i]<=1.
  - Snoop also compares alloc_addr of a same-cycle allocation; a match sets hazard in the new entry (conservative).
- Commit:
  - misload = (commit_entry!=0) && valid[commit_entry] && hazard[commit_entry], combinational, same cycle.
  - On the edge: valid[commit_entry]<=0 and hazard<=0, regardless of misload.
  - commit_entry pointing to an invalid entry: misload=0, no state change.
- Same-cycle alloc and commit: the entry freed by commit is not reused that cycle, because free_entry comes from pre-edge state.
- Same-cycle store snoop and commit of the same entry: the commit clears the entry; snoop has no effect on it. The ROB commits one instruction per cycle, so store_we and commit_entry!=0 never coincide in legal operation.
- flush: on the next edge all valid and hazard bits clear. flush has priority over alloc, snoop and commit in that cycle. misload is still driven combinationally during the flush cycle.
- occupancy: registered popcount of valid, updated each edge.
- Reset asserted mid-operation: immediate clear; no partial state survives.

Optional Feature:
- LOADBUF_STATS_EN:
  - Defined: adds output misload_count [15:0]. It increments by 1 on every edge where misload=1, saturates at 16'hFFFF, and resets to 0 on reset_n only (not on flush).
  - Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package (core constants header):
  - LOADBUF_IDX_W, LOADBUF_ENTRIES=7, LOADBUF_NONE=3'd0.
  - A packed struct loadbuf_entry_t {valid, hazard, addr}.
- Natural sub-module: loadbuf_prio_enc, a lowest-free-index priority encoder. It takes the valid vector and outputs index plus full.
- Address comparators stay inline as a generate loop.

Test Plan:
- Fill: alloc_en for 8 consecutive cycles, addrs 0x100..0x11C, no commits -> free_entry 1..7, then 0 with full=1 after the 7th edge; occupancy=7.
- Hazard: alloc entry1 addr 0x200; store_we addr 0x203 (same word); commit_entry=1 -> misload=1 that cycle; entry1 freed next edge.
- No hazard: alloc entry1 addr 0x200; store_we addr 0x204; commit_entry=1 -> misload=0.
- Same-cycle: alloc 0x300 while store_we 0x300 -> new entry hazard=1. Separately, free entry2 while allocating -> grant is not 2 that cycle, and is 2 the next cycle.
- Flush: 5 valid entries with hazards, flush=1 -> next cycle occupancy=0, free_entry=1, a subsequent commit_entry=3 gives misload=0.
- Async reset: drop reset_n between edges with entries valid -> outputs reach reset values before the next clk edge. With LOADBUF_STATS_EN defined, misload_count=0 after reset and unchanged across a flush.

Source files
------------

// File: rtl/load_buffer_pkg.sv
// Shared constants and entry type for the speculative load buffer.
package load_buffer_pkg;

    localparam int unsigned LOADBUF_IDX_W     = 3;
    localparam int unsigned LOADBUF_ENTRIES   = (1 << LOADBUF_IDX_W) - 1;
    localparam int unsigned LOADBUF_ADDR_W    = 32;
    localparam int unsigned LOADBUF_MATCH_LSB = 2;
    localparam int unsigned LOADBUF_CNT_W     = 16;

    // Index 0 is reserved to mean "no entry"
    localparam logic [LOADBUF_IDX_W-1:0] LOADBUF_NONE = LOADBUF_IDX_W'(0);

    typedef struct packed {
        logic                      valid;
        logic                      hazard;
        logic [LOADBUF_ADDR_W-1:0] addr;
    } loadbuf_entry_t;

endpackage

// File: rtl/loadbuf_prio_enc.sv
// Lowest-free-index priority encoder: bit i of valid is entry i+1.
module loadbuf_prio_enc
    import load_buffer_pkg::*;
#(
    parameter int unsigned NUM   = LOADBUF_ENTRIES,
    parameter int unsigned IDX_W = LOADBUF_IDX_W
) (
    input  logic [NUM-1:0]   valid,
    output logic [IDX_W-1:0] free_idx_c,
    output logic             full_c
);

    // Scan from the top down so the lowest free index wins
    always_comb begin
        free_idx_c = '0;
        for (int i = int'(NUM) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx_c = IDX_W'(i + 1);
            end
        end
    end

    assign full_c = &valid;

endmodule

// File: rtl/load_buffer.sv
// Speculative load buffer: tracks issued loads until ROB commit and flags
// loads that were overtaken by an older same-word committed store.
// Optional build macro: LOADBUF_STATS_EN adds the misload_count output.
module load_buffer
    import load_buffer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       alloc_en,
    input  logic [LOADBUF_ADDR_W-1:0]  alloc_addr,
    output logic [LOADBUF_IDX_W-1:0]   free_entry,
    output logic                       full,
    input  logic                       store_we,
    input  logic [LOADBUF_ADDR_W-1:0]  store_addr,
    input  logic [LOADBUF_IDX_W-1:0]   commit_entry,
    output logic                       misload,
    output logic [LOADBUF_IDX_W-1:0]   occupancy
`ifdef LOADBUF_STATS_EN
    ,
    output logic [LOADBUF_CNT_W-1:0]   misload_count
`endif
);

    localparam int unsigned IDX_W     = LOADBUF_IDX_W;
    localparam int unsigned NUM       = LOADBUF_ENTRIES;
    localparam int unsigned ADDR_W    = LOADBUF_ADDR_W;
    localparam int unsigned MATCH_LSB = LOADBUF_MATCH_LSB;

    loadbuf_entry_t   ent_q [1:NUM];
    loadbuf_entry_t   ent_d [1:NUM];
    logic [NUM:0]     valid_v;
    logic [NUM:0]     hazard_v;
    logic [NUM:1]     snoop_hit;
    logic [NUM:1]     alloc_hit;
    logic [NUM:1]     commit_hit;
    logic [IDX_W-1:0] grant_c;
    logic             full_c;
    logic             alloc_fire;
    logic             alloc_snoop_hit;
    logic [IDX_W-1:0] occ_d;
    logic             store_addr_unused;

    // Byte offset within a word never participates in the match
    assign store_addr_unused = ^store_addr[MATCH_LSB-1:0];

    // Grant comes from pre-edge valid bits only
    loadbuf_prio_enc #(
        .NUM   (NUM),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .valid      (valid_v[NUM:1]),
        .free_idx_c (grant_c),
        .full_c     (full_c)
    );

    assign free_entry = grant_c;
    assign full       = full_c;
    assign alloc_fire = alloc_en && !full_c;

    // A same-cycle allocation hit by the store is marked stale conservatively
    assign alloc_snoop_hit = store_we &&
        (alloc_addr[ADDR_W-1:MATCH_LSB] == store_addr[ADDR_W-1:MATCH_LSB]);

    assign valid_v[0]  = 1'b0;
    assign hazard_v[0] = 1'b0;

    // Per-entry store comparators and alloc/commit decode
    for (genvar gi = 1; gi <= NUM; gi++) begin : g_entry
        assign valid_v[gi]    = ent_q[gi].valid;
        assign hazard_v[gi]   = ent_q[gi].hazard;
        assign snoop_hit[gi]  = store_we && ent_q[gi].valid &&
            (ent_q[gi].addr[ADDR_W-1:MATCH_LSB] == store_addr[ADDR_W-1:MATCH_LSB]);
        assign alloc_hit[gi]  = alloc_fire && (grant_c == IDX_W'(gi));
        assign commit_hit[gi] = ent_q[gi].valid && (commit_entry == IDX_W'(gi));
    end

    // Slot 0 holds zeros, so "no entry" never reports a misload
    assign misload = valid_v[commit_entry] && hazard_v[commit_entry];

    // Next entry state: flush > commit > alloc > snoop
    always_comb begin
        occ_d = '0;
        for (int i = 1; i <= int'(NUM); i++) begin
            ent_d[i] = ent_q[i];
            if (flush) begin
                ent_d[i].valid  = 1'b0;
                ent_d[i].hazard = 1'b0;
            end else if (commit_hit[i]) begin
                ent_d[i].valid  = 1'b0;
                ent_d[i].hazard = 1'b0;
            end else if (alloc_hit[i]) begin
                ent_d[i].valid  = 1'b1;
                ent_d[i].addr   = alloc_addr;
                ent_d[i].hazard = alloc_snoop_hit;
            end else if (snoop_hit[i]) begin
                ent_d[i].hazard = 1'b1;
            end
            occ_d = occ_d + IDX_W'(ent_d[i].valid);
        end
    end

    // Entry storage and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= int'(NUM); i++) begin
                ent_q[i] <= '0;
            end
            occupancy <= '0;
        end else begin
            for (int i = 1; i <= int'(NUM); i++) begin
                ent_q[i] <= ent_d[i];
            end
            occupancy <= occ_d;
        end
    end

`ifdef LOADBUF_STATS_EN
    // Saturating misload counter, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misload_count <= '0;
        end else if (misload && (misload_count != '1)) begin
            misload_count <= misload_count + LOADBUF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_load_buffer.sv
// Scoreboard bench for load_buffer: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_load_buffer;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        alloc_en;
    logic [31:0] alloc_addr;
    logic [2:0]  free_entry;
    logic        full;
    logic        store_we;
    logic [31:0] store_addr;
    logic [2:0]  commit_entry;
    logic        misload;
    logic [2:0]  occupancy;
`ifdef LOADBUF_STATS_EN
    logic [15:0] misload_count;
`endif

    localparam int S_FREE = 0;
    localparam int S_FULL = 1;
    localparam int S_MIS  = 2;
    localparam int S_OCC  = 3;
    localparam int S_CNT  = 4;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   passes;
    int   exp_cnt;

    load_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .alloc_en     (alloc_en),
        .alloc_addr   (alloc_addr),
        .free_entry   (free_entry),
        .full         (full),
        .store_we     (store_we),
        .store_addr   (store_addr),
        .commit_entry (commit_entry),
        .misload      (misload),
        .occupancy    (occupancy)
`ifdef LOADBUF_STATS_EN
        ,
        .misload_count(misload_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int sig);
        case (sig)
            S_FREE:  return "free_entry";
            S_FULL:  return "full";
            S_MIS:   return "misload";
            S_OCC:   return "occupancy";
            S_CNT:   return "misload_count";
            default: return "unknown";
        endcase
    endfunction

    function automatic int sample(input int sig);
        case (sig)
            S_FREE:  return int'(free_entry);
            S_FULL:  return int'(full);
            S_MIS:   return int'(misload);
            S_OCC:   return int'(occupancy);
`ifdef LOADBUF_STATS_EN
            S_CNT:   return int'(misload_count);
`endif
            default: return -1;
        endcase
    endfunction

    task automatic push_exp(input int sig, input int val);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due this cycle, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        int   got;
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            got = sample(e.sig);
            checks++;
            if (got == e.val) begin
                passes++;
            end else begin
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                         sig_name(e.sig), got, e.val, cyc);
            end
        end
    end

    initial begin
        int st_addr [5];
        st_addr = '{32'h400, 32'h410, 32'h408, 32'h40C, 32'h500};
        checks       = 0;
        passes       = 0;
        exp_cnt      = 0;
        reset_n      = 1'b0;
        flush        = 1'b0;
        alloc_en     = 1'b0;
        alloc_addr   = '0;
        store_we     = 1'b0;
        store_addr   = '0;
        commit_entry = '0;

        // Reset values
        next_cycle();
        next_cycle();
        push_exp(S_FREE, 1);
        push_exp(S_FULL, 0);
        push_exp(S_MIS, 0);
        push_exp(S_OCC, 0);
        next_cycle();
        reset_n = 1'b1;

        // Fill: eight consecutive allocations, the eighth meets full
        for (int k = 0; k < 8; k++) begin
            alloc_en   = 1'b1;
            alloc_addr = 32'h100 + 32'(4 * k);
            push_exp(S_FREE, (k < 7) ? k + 1 : 0);
            push_exp(S_FULL, (k == 7) ? 1 : 0);
            push_exp(S_OCC, k);
            next_cycle();
        end
        alloc_en = 1'b0;

        checks++;
        if (occupancy == 3'd7) passes++;
        else $display("FAIL direct: occupancy %0d after fill, expected 7", occupancy);
        checks++;
        if (full == 1'b1) passes++;
        else $display("FAIL direct: full %0d after fill, expected 1", full);
        checks++;
        if (free_entry == 3'd0) passes++;
        else $display("FAIL direct: free_entry %0d after fill, expected 0", free_entry);

        push_exp(S_OCC, 7);
        push_exp(S_FULL, 1);
        push_exp(S_FREE, 0);

        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        push_exp(S_OCC, 0);
        push_exp(S_FREE, 1);
        push_exp(S_FULL, 0);

        // Hazard: same-word store commits before the load
        alloc_en   = 1'b1;
        alloc_addr = 32'h200;
        push_exp(S_FREE, 1);
        next_cycle();
        alloc_en   = 1'b0;
        store_we   = 1'b1;
        store_addr = 32'h203;
        push_exp(S_OCC, 1);
        next_cycle();
        store_we     = 1'b0;
        commit_entry = 3'd1;
        push_exp(S_MIS, 1);
        exp_cnt++;
        next_cycle();
        push_exp(S_OCC, 0);
        push_exp(S_FREE, 1);
        push_exp(S_MIS, 0);
        next_cycle();
        commit_entry = 3'd0;

        // No hazard: store to the neighbouring word
        alloc_en   = 1'b1;
        alloc_addr = 32'h200;
        next_cycle();
        alloc_en   = 1'b0;
        store_we   = 1'b1;
        store_addr = 32'h204;
        next_cycle();
        store_we     = 1'b0;
        commit_entry = 3'd1;
        push_exp(S_MIS, 0);
        next_cycle();
        commit_entry = 3'd0;
        push_exp(S_OCC, 0);

        // Same-cycle alloc and store snoop marks the new entry
        alloc_en   = 1'b1;
        alloc_addr = 32'h300;
        store_we   = 1'b1;
        store_addr = 32'h300;
        push_exp(S_FREE, 1);
        next_cycle();
        alloc_en     = 1'b0;
        store_we     = 1'b0;
        commit_entry = 3'd1;
        push_exp(S_MIS, 1);
        exp_cnt++;
        next_cycle();
        commit_entry = 3'd0;
        push_exp(S_OCC, 0);

        // Freed entry is not regranted in its commit cycle
        alloc_en   = 1'b1;
        alloc_addr = 32'h400;
        next_cycle();
        alloc_addr = 32'h404;
        push_exp(S_FREE, 2);
        next_cycle();
        alloc_addr = 32'h408;
        next_cycle();
        alloc_addr   = 32'h40C;
        commit_entry = 3'd2;
        push_exp(S_FREE, 4);
        push_exp(S_MIS, 0);
        push_exp(S_OCC, 3);
        next_cycle();
        commit_entry = 3'd0;
        alloc_addr   = 32'h410;
        push_exp(S_FREE, 2);
        push_exp(S_OCC, 3);
        next_cycle();
        alloc_addr = 32'h500;
        push_exp(S_FREE, 5);
        push_exp(S_OCC, 4);
        next_cycle();
        alloc_en = 1'b0;
        push_exp(S_OCC, 5);
        push_exp(S_FREE, 6);

        // Put a hazard on all five live entries
        for (int s = 0; s < 5; s++) begin
            store_we   = 1'b1;
            store_addr = st_addr[s];
            next_cycle();
        end
        store_we = 1'b0;

        // Flush: misload still visible this cycle, then everything clears
        flush        = 1'b1;
        commit_entry = 3'd3;
        push_exp(S_MIS, 1);
        exp_cnt++;
        next_cycle();
        flush = 1'b0;
        push_exp(S_OCC, 0);
        push_exp(S_FREE, 1);
        push_exp(S_MIS, 0);
`ifdef LOADBUF_STATS_EN
        push_exp(S_CNT, exp_cnt);
`endif
        next_cycle();
        commit_entry = 3'd0;

        // Async reset between edges with live entries
        alloc_en   = 1'b1;
        alloc_addr = 32'h600;
        store_we   = 1'b1;
        store_addr = 32'h600;
        next_cycle();
        store_we   = 1'b0;
        alloc_addr = 32'h604;
        push_exp(S_OCC, 1);
        next_cycle();
        alloc_en     = 1'b0;
        commit_entry = 3'd1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (occupancy == 3'd0) passes++;
        else $display("FAIL direct: occupancy %0d in async reset, expected 0", occupancy);
        checks++;
        if (free_entry == 3'd1) passes++;
        else $display("FAIL direct: free_entry %0d in async reset, expected 1", free_entry);
        exp_cnt = 0;
        push_exp(S_OCC, 0);
        push_exp(S_FREE, 1);
        push_exp(S_FULL, 0);
        push_exp(S_MIS, 0);
`ifdef LOADBUF_STATS_EN
        push_exp(S_CNT, exp_cnt);
`endif
        next_cycle();
        commit_entry = 3'd0;
        reset_n      = 1'b1;
        push_exp(S_OCC, 0);
        push_exp(S_FREE, 1);
        next_cycle();

        // Let the monitor drain, then report anything left unchecked
        for (int w = 0; w < 4 && exp_q.size() != 0; w++) begin
            next_cycle();
        end
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            $display("FAIL %s: never compared, expected %0d (cycle %0d)",
                     sig_name(e.sig), e.val, e.cyc);
        end

        $display("%0d/%0d checks passed", passes, checks);
        if (passes == checks) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule
